// File: rtl/audio_pkg.sv
// Shared constants and types for the audio mix scheduler.
package audio_pkg;

  localparam int unsigned SampleW = 16;
  localparam int SatMax = 32767;
  localparam int SatMin = -32768;

  typedef enum logic [1:0] {
    Gain0 = 2'd0,
    Gain1 = 2'd1,
    Gain2 = 2'd2,
    Gain3 = 2'd3
  } gain_shift_e;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StSat,
    StHold
  } mix_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant per cycle, search starts at the rotating pointer.
module rr_arbiter
  import audio_pkg::*;
#(
  parameter int unsigned NSRC = 3
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  input  logic [NSRC-1:0] i_req,
  output logic [NSRC-1:0] o_gnt
);
  localparam int unsigned PW = idx_w(NSRC);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_d;
  logic          w_found;
  int unsigned   w_idx;

  always_comb begin
    o_gnt   = '0;
    w_ptr_d = r_ptr;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned o = 0; o < NSRC; o++) begin
      w_idx = (32'(r_ptr) + o) % NSRC;
      if (!w_found && i_req[w_idx[PW-1:0]]) begin
        w_found                 = 1'b1;
        o_gnt[w_idx[PW-1:0]]    = 1'b1;
        w_ptr_d                 = PW'((w_idx + 1) % NSRC);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_d;
    end
  end

endmodule

// File: rtl/audio_mix_sched.sv
// Audio mix scheduler: round-robin sample capture, per-frame gain/saturating mix.
// Build option AUDIO_MIX_STALE_MUTE_EN mutes sources with no new sample for 4 frames.
module audio_mix_sched
  import audio_pkg::*;
#(
  parameter int unsigned NSRC  = 3,
  parameter int unsigned FRAME = 512,
  parameter int unsigned AW    = 19
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic [NSRC-1:0]         i_src_req,
  input  logic [SampleW*NSRC-1:0] i_src_l,
  input  logic [SampleW*NSRC-1:0] i_src_r,
  input  logic [2*NSRC-1:0]       i_src_gain,
  output logic [NSRC-1:0]         o_src_ack,
  output logic [SampleW-1:0]      o_l,
  output logic [SampleW-1:0]      o_r,
  output logic                    o_frame,
  output logic                    o_clip
);
  localparam int unsigned PW = idx_w(NSRC);
  localparam int unsigned FW = idx_w(FRAME);
  localparam logic [FW-1:0] FcLast = FW'(FRAME - 1);
  localparam logic signed [AW-1:0] LimHi = AW'(SatMax);
  localparam logic signed [AW-1:0] LimLo = AW'(SatMin);

  mix_state_e                r_state, w_state_d;
  logic [FW-1:0]             r_fc;
  logic [PW-1:0]             r_k;
  logic [NSRC-1:0]           w_gnt;
  logic                      w_frame;
  logic signed [SampleW-1:0] r_slot_l [NSRC];
  logic signed [SampleW-1:0] r_slot_r [NSRC];
  logic signed [AW-1:0]      r_acc_l, r_acc_r, w_add_l, w_add_r;
  logic signed [SampleW-1:0] w_sel_l, w_sel_r, w_shl_l, w_shl_r;
  logic signed [SampleW-1:0] w_sat_l, w_sat_r;
  logic [SampleW-1:0]        r_pend_l, r_pend_r, r_l, r_r;
  logic                      r_clip, w_clamp, w_mute;
  gain_shift_e               w_gain;

  rr_arbiter #(
    .NSRC(NSRC)
  ) u_arb (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_req    (i_src_req),
    .o_gnt    (w_gnt)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        r_slot_l[i] <= '0;
        r_slot_r[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (w_gnt[i]) begin
          r_slot_l[i] <= i_src_l[SampleW*i +: SampleW];
          r_slot_r[i] <= i_src_r[SampleW*i +: SampleW];
        end
      end
    end
  end

`ifdef AUDIO_MIX_STALE_MUTE_EN
  localparam logic [2:0] StaleMax = 3'd4;
  logic [2:0]      r_stale [NSRC];
  logic [NSRC-1:0] r_seen;

  // r_seen marks sources granted since the last frame pulse.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < NSRC; i++) r_stale[i] <= '0;
      r_seen <= '0;
    end else begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (w_gnt[i]) begin
          r_stale[i] <= '0;
        end else if (w_frame && !r_seen[i] && r_stale[i] != StaleMax) begin
          r_stale[i] <= r_stale[i] + 3'd1;
        end
      end
      r_seen <= w_frame ? '0 : (r_seen | w_gnt);
    end
  end
`endif

  always_comb begin
    w_sel_l = '0;
    w_sel_r = '0;
    w_gain  = Gain0;
    w_mute  = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (r_k == PW'(i)) begin
        w_sel_l = r_slot_l[i];
        w_sel_r = r_slot_r[i];
        w_gain  = gain_shift_e'(i_src_gain[2*i +: 2]);
`ifdef AUDIO_MIX_STALE_MUTE_EN
        w_mute  = (r_stale[i] == StaleMax);
`endif
      end
    end
    w_shl_l = w_sel_l >>> w_gain;
    w_shl_r = w_sel_r >>> w_gain;
    w_add_l = w_mute ? '0 : {{(AW-SampleW){w_shl_l[SampleW-1]}}, w_shl_l};
    w_add_r = w_mute ? '0 : {{(AW-SampleW){w_shl_r[SampleW-1]}}, w_shl_r};
  end

  always_comb begin
    w_clamp = 1'b0;
    w_sat_l = r_acc_l[SampleW-1:0];
    w_sat_r = r_acc_r[SampleW-1:0];
    if (r_acc_l > LimHi) begin
      w_sat_l = LimHi[SampleW-1:0];
      w_clamp = 1'b1;
    end else if (r_acc_l < LimLo) begin
      w_sat_l = LimLo[SampleW-1:0];
      w_clamp = 1'b1;
    end
    if (r_acc_r > LimHi) begin
      w_sat_r = LimHi[SampleW-1:0];
      w_clamp = 1'b1;
    end else if (r_acc_r < LimLo) begin
      w_sat_r = LimLo[SampleW-1:0];
      w_clamp = 1'b1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_frame   = 1'b0;
    unique case (r_state)
      StIdle: if (r_fc == '0) w_state_d = StAcc;
      StAcc:  if (r_k == PW'(NSRC - 1)) w_state_d = StSat;
      StSat:  w_state_d = StHold;
      StHold: begin
        if (r_fc == FcLast) begin
          w_frame   = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= StIdle;
      r_fc     <= '0;
      r_k      <= '0;
      r_acc_l  <= '0;
      r_acc_r  <= '0;
      r_pend_l <= '0;
      r_pend_r <= '0;
      r_l      <= '0;
      r_r      <= '0;
      r_clip   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_fc    <= (r_fc == FcLast) ? '0 : r_fc + 1'b1;
      unique case (r_state)
        StIdle: begin
          if (r_fc == '0) begin
            r_acc_l <= '0;
            r_acc_r <= '0;
            r_k     <= '0;
          end
        end
        StAcc: begin
          r_acc_l <= r_acc_l + w_add_l;
          r_acc_r <= r_acc_r + w_add_r;
          r_k     <= r_k + 1'b1;
        end
        StSat: begin
          r_pend_l <= w_sat_l;
          r_pend_r <= w_sat_r;
          if (w_clamp) r_clip <= 1'b1;
        end
        StHold: begin
          if (w_frame) begin
            r_l <= r_pend_l;
            r_r <= r_pend_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_src_ack = w_gnt;
  assign o_l       = r_l;
  assign o_r       = r_r;
  assign o_frame   = w_frame;
  assign o_clip    = r_clip;

endmodule

// File: tb/tb_audio_mix_sched.sv
// Scoreboard bench for audio_mix_sched; expected frame outputs are queued by the stimulus.
module tb_audio_mix_sched;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        clip;
  } exp_t;

  typedef struct packed {
    logic [2:0]  req;
    logic [47:0] l;
    logic [47:0] r;
    logic [5:0]  g;
    logic [15:0] el;
    logic [15:0] er;
    logic        ec;
  } vec_t;

  localparam int NV = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [47:0] src_l, src_r;
  logic [5:0]  gain;
  logic [2:0]  ack;
  logic [15:0] l, r;
  logic        frame, clip;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc;
  int   bad_onehot = 0;
  int   early_acks = 0;
  bit   main_phase = 0;
  exp_t q[$];
  vec_t vecs [NV];

  audio_mix_sched #(
    .NSRC (3),
    .FRAME(512),
    .AW   (19)
  ) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_src_req (req),
    .i_src_l   (src_l),
    .i_src_r   (src_r),
    .i_src_gain(gain),
    .o_src_ack (ack),
    .o_l       (l),
    .o_r       (r),
    .o_frame   (frame),
    .o_clip    (clip)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (!$onehot0(ack)) bad_onehot <= bad_onehot + 1;
      if (main_phase && cyc < 1024 && ack != 3'b000) early_acks <= early_acks + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] rq, input int l0, input int l1, input int l2,
                              input int r0, input int r1, input int r2, input int g0,
                              input int g1, input int g2, input int el, input int er,
                              input logic ec);
    vec_t v;
    v.req = rq;
    v.l   = {16'(l2), 16'(l1), 16'(l0)};
    v.r   = {16'(r2), 16'(r1), 16'(r0)};
    v.g   = {2'(g2), 2'(g1), 2'(g0)};
    v.el  = 16'(el);
    v.er  = 16'(er);
    v.ec  = ec;
    return v;
  endfunction

  // Monitor: on each frame pulse, the new l/r/clip are visible after the next edge.
  initial begin : monitor
    int   npulse;
    exp_t e;
    npulse = 0;
    forever begin
      @(negedge clk);
      if (rst_n && main_phase && frame) begin
        if (npulse < 2) chk("frame_cycle", 32'(cyc), 32'(511 + 512 * npulse));
        npulse++;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("mix_l", 32'(l), 32'(e.l));
          chk("mix_r", 32'(r), 32'(e.r));
          chk("clip", 32'(clip), 32'(e.clip));
        end
      end
    end
  end

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame && n < 600);
    if (!frame) chk("frame_timeout", 32'(frame), 32'd1);
  endtask

  task automatic apply(input vec_t v, input bit chk_order);
    logic [2:0] pend;
    logic [2:0] a;
    int         ord [3];
    int         tc [3];
    int         nord;
    @(negedge clk);
    src_l = v.l;
    src_r = v.r;
    gain  = v.g;
    req   = v.req;
    pend  = v.req;
    nord  = 0;
    for (int c = 0; c < 12 && pend != 3'b000; c++) begin
      #1;
      a = ack;
      for (int i = 0; i < 3; i++) begin
        if (a[i] && nord < 3) begin
          ord[nord] = i;
          tc[nord]  = cyc;
          nord++;
        end
      end
      @(posedge clk);
      #1;
      pend = pend & ~a;
      req  = pend;
      @(negedge clk);
    end
    if (pend != 3'b000) chk("ack_timeout", 32'(pend), 32'd0);
    req = 3'b000;
    if (chk_order) begin
      chk("ack_order", {8'(ord[0]), 8'(ord[1]), 8'(ord[2])}, {8'd0, 8'd1, 8'd2});
      chk("ack_spacing", 32'(tc[2] - tc[0]), 32'd2);
    end
  endtask

  // Source 0 holds its request; source 2 asserts once at the third cycle.
  task automatic fair_run(input vec_t v);
    logic [2:0] a;
    logic [2:0] seq [6];
    bit         got2;
    seq[0] = 3'b001; seq[1] = 3'b001; seq[2] = 3'b100;
    seq[3] = 3'b001; seq[4] = 3'b001; seq[5] = 3'b001;
    got2 = 0;
    @(negedge clk);
    src_l = v.l;
    src_r = v.r;
    gain  = v.g;
    req   = 3'b001;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) req[2] = 1'b1;
      #1;
      a = ack;
      chk("fair_seq", 32'(a), 32'(seq[c]));
      if (a[2] && c <= 4) got2 = 1;
      @(posedge clk);
      #1;
      if (a[2]) req[2] = 1'b0;
      @(negedge clk);
    end
    req = 3'b000;
    chk("src2_latency", 32'(got2), 32'd1);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    exp_t prev;
    int   n;
    vecs[0]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    vecs[1]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    vecs[2]  = mk(3'b111, 1000, 2000, 3000, -1000, -2000, -3000, 0, 0, 0, 6000, -6000, 1'b0);
    vecs[3]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6000, -6000, 1'b0);
    vecs[4]  = mk(3'b111, 32767, 32767, 32767, -32768, -32768, -32768, 0, 0, 0,
                  32767, -32768, 1'b1);
    vecs[5]  = mk(3'b111, -32768, -32768, -32768, 32767, 32767, 32767, 0, 0, 0,
                  -32768, 32767, 1'b1);
    vecs[6]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, -32768, 32767, 1'b1);
    vecs[7]  = mk(3'b111, 0, -1, 0, 0, -1, 0, 0, 3, 0, -1, -1, 1'b1);
    vecs[8]  = mk(3'b111, 16, 0, 0, -16, 0, 0, 2, 0, 0, 4, -4, 1'b1);
    vecs[9]  = mk(3'b101, 100, 0, 5, 50, 0, 7, 0, 0, 0, 105, 57, 1'b1);
    vecs[10] = mk(3'b111, -5, 7, -9, 300, -300, 1, 1, 1, 1, -5, 0, 1'b1);
    vecs[11] = mk(3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    vecs[12] = mk(3'b001, 1000, 0, 0, -1000, 0, 0, 0, 0, 0, 1000, -1000, 1'b1);
    vecs[13] = mk(3'b000, 1000, 0, 0, -1000, 0, 0, 0, 0, 0, 1000, -1000, 1'b1);
    vecs[14] = mk(3'b000, 1000, 0, 0, -1000, 0, 0, 0, 0, 0, 1000, -1000, 1'b1);
    vecs[15] = mk(3'b000, 1000, 0, 0, -1000, 0, 0, 0, 0, 0, 1000, -1000, 1'b1);
`ifdef AUDIO_MIX_STALE_MUTE_EN
    vecs[16] = mk(3'b000, 1000, 0, 0, -1000, 0, 0, 0, 0, 0, 0, 0, 1'b1);
`else
    vecs[16] = mk(3'b000, 1000, 0, 0, -1000, 0, 0, 0, 0, 0, 1000, -1000, 1'b1);
`endif
    vecs[17] = mk(3'b001, 1000, 0, 0, -1000, 0, 0, 0, 0, 0, 1000, -1000, 1'b1);
    vecs[18] = mk(3'b000, 1000, 0, 0, -1000, 0, 0, 0, 0, 0, 1000, -1000, 1'b1);
    vecs[19] = mk(3'b000, 1000, 0, 0, -1000, 0, 0, 0, 0, 0, 1000, -1000, 1'b1);

    rst_n = 1'b0;
    req   = 3'b000;
    src_l = '0;
    src_r = '0;
    gain  = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({l, r, frame, clip, ack}), 32'd0);
    rst_n = 1'b1;

    // Capture a sample, then reset mid-frame: the slot must not survive.
    repeat (10) @(negedge clk);
    src_l[15:0] = 16'd500;
    src_r[15:0] = 16'd500;
    req = 3'b001;
    @(negedge clk);
    req = 3'b000;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async", 32'({l, r, frame, clip, ack}), 32'd0);
    repeat (2) @(negedge clk);
    src_l = '0;
    src_r = '0;
    rst_n = 1'b1;
    main_phase = 1;

    prev = '{l: 16'd0, r: 16'd0, clip: 1'b0};
    for (int s = 0; s < NV; s++) begin
      if (s > 0) wait_frame();
      repeat (20) @(negedge clk);
      q.push_back(prev);
      if (s == 9) fair_run(vecs[s]);
      else        apply(vecs[s], s == 2);
      prev = '{l: vecs[s].el, r: vecs[s].er, clip: vecs[s].ec};
    end

    n = 0;
    while (q.size() > 0 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("ack_onehot", 32'(bad_onehot), 32'd0);
    chk("quiet_no_ack", 32'(early_acks), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/audio_mix_sched.md
Name: audio_mix_sched

Overview:
- Front-end controller for the I2S serializer.
- Collects stereo samples from several audio requesters (beeper, tape monitor, sound chip) through a round-robin request/ack handshake.
- Mixes the latest sample from each requester with a per-source gain shift and saturation.
- Presents the serializer's 16-bit l/r inputs, updated only at frame boundaries, so they never change mid-shift.

Parameters:
- NSRC, 3: number of requesters (1..8).
- FRAME, 512: clock cycles per stereo frame; must match the serializer's 9-bit divider period.
- AW, 19: accumulator width; must be at least 16 + ceil(log2(NSRC)) + 1.

Ports:
- clock  in  1  system clock, same clock as the serializer.
- reset  in  1  asynchronous, active-low reset.
- src_req  in  NSRC  level request; source i has a new sample on src_l/src_r.
- src_l  in  16*NSRC  signed left sample; slice i = [16*i+15:16*i].
- src_r  in  16*NSRC  signed right sample; same slicing.
- src_gain  in  2*NSRC  per-source attenuation as an arithmetic right shift, 0..3.
- src_ack  out  NSRC  one-cycle pulse; the sample of source i is captured this cycle.
- l  out  16  mixed left sample to the serializer.
- r  out  16  mixed right sample to the serializer.
- frame  out  1  one-cycle pulse in the cycle l/r update.
- clip  out  1  sticky; set when any frame saturated, cleared by reset only.

Behaviour:
- Reset values: all outputs 0. Slots, pending registers, accumulators and the frame counter are cleared. Round-robin pointer = 0.
- Frame counter fc: 0..FRAME-1, increments every clock and wraps to 0. It is free-running from reset release.
- Arbiter:
  - Each cycle, at most one pending request is granted. Search order starts at pointer p.
  - On grant of source i: slot_l[i]/slot_r[i] <= src_l/src_r slices, src_ack[i]=1 for that cycle, p <= (i+1) mod NSRC.
  - With no requests, p holds.
  - A requester holding src_req high after its ack gets a new grant no earlier than the round-robin order allows. Worst-case wait is NSRC-1 cycles.
  - Back-to-back grants to the same source are allowed when it is the only requester.
- Mix FSM states: IDLE, ACC, SAT, HOLD.
  - IDLE -> ACC when fc==0. Accumulators are cleared and index k = 0.
  - ACC: one source per cycle. acc_l += sign-extended (slot_l[k] >>> gain[k]); same for right. k increments. After k == NSRC-1 the FSM moves to SAT.
  - Slot read versus grant write to the same slot in the same cycle: ACC uses the pre-write value.
  - SAT: clamp each AW-bit accumulator to [-32768, 32767]. Write pending_l/pending_r. Set clip if either channel clamped. Next state HOLD.
  - HOLD: wait. At fc==FRAME-1: l<=pending_l, r<=pending_r, frame=1, then IDLE.
  - End-to-end latency from the frame start to the l/r update is fixed at FRAME cycles.
- Sample hold: a slot with no new request during a frame keeps its last value and is re-mixed.
- Reset mid-frame: everything returns to reset values immediately. The first frame pulse occurs FRAME cycles after reset release, carrying l=r=0 plus whatever was captured by fc=0.
- Width rule: all arithmetic is signed. The gain shift is arithmetic, so -1 >>> 3 = -1.

Optional Feature:
- Macro: AUDIO_MIX_STALE_MUTE_EN.
- With the macro defined:
  - Each source has a 3-bit stale counter. It is cleared on grant and incremented (saturating at 4) at each frame pulse without a grant in that frame.
  - While the counter reads 4, the source contributes 0 to the mix.
- Without the macro: no counters, and stale slots are mixed indefinitely.

Decomposition:
- Shared package audio_pkg: sample width constant (16), saturation limits, and the gain-shift enum.
- One natural sub-module, rr_arbiter. It is parameterised on NSRC and takes the req vector, outputs a one-hot grant, and holds the rotating pointer. audio_mix_sched uses it directly.

Test Plan:
- Reset, then no requests for 2 frames -> l=r=0. frame pulses at cycles 511 and 1023 after reset release. src_ack stays 0.
- Sources 0,1,2 request simultaneously, holding L=1000, 2000, 3000 (R = negatives), gain 0 -> acks in cycles t, t+1, t+2 (order 0,1,2). The next frame gives l=6000, r=-6000.
- All three sources at 32767, gain 0 -> l=32767, clip=1 and stays 1 after later quiet frames. Same test with -32768 -> l=-32768.
- Gain check: source 1 = -1 with gain 3, others 0 -> l=-1; source 0 = 16 with gain 2, alone -> l=4.
- Source 0 requests continuously while source 2 requests once -> source 2 is acked within 2 cycles of asserting req. The grant sequence alternates fairly.
- AUDIO_MIX_STALE_MUTE_EN build: source 0 delivers 1000 once, then goes silent -> l=1000 for 4 frames, then 0 from the 5th frame onward. A new request restores the contribution at the next frame.
